// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 uart_tx among byte-stream requesters.
// A grant is held for a packet, until valid drops, or for MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_active
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

  state_t                  state, state_n;
  logic [ID_W-1:0]         rr_ptr, rr_n;
  logic [ID_W-1:0]         gid_n, pick;
  logic                    act_n, found;
  logic                    last_q, last_n;
  logic [7:0]              burst_cnt, burst_n;
  logic [DATA_WIDTH-1:0]   data_n, sel_data;
  logic                    sel_valid, sel_last;
  logic [NUM_REQ-1:0]      rot;
  int                      s;

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  // Rotate so bit 0 is the requester just after the last owner.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ({1'b0, rr_ptr} + 1'b1));
    found = 1'b0;
    pick  = '0;
    s     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s = int'(rr_ptr) + 1 + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        pick = ID_W'(s);
      end
    end
  end

  always_comb begin
    state_n   = state;
    gid_n     = grant_id;
    act_n     = grant_active;
    rr_n      = rr_ptr;
    burst_n   = burst_cnt;
    data_n    = tx_data;
    last_n    = last_q;
    req_ready = '0;
    tx_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gid_n   = pick;
          act_n   = 1'b1;
          burst_n = '0;
          state_n = ACCEPT;
        end
      end
      ACCEPT: begin
        if (sel_valid) begin
          req_ready = NUM_REQ'(1) << grant_id;
          data_n    = sel_data;
          last_n    = sel_last;
          state_n   = START;
        end else begin
          act_n   = 1'b0;
          rr_n    = grant_id;
          state_n = IDLE;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_q && burst_cnt < BURST_LIM) begin
            burst_n = burst_cnt + 8'd1;
            state_n = ACCEPT;
          end else begin
            act_n   = 1'b0;
            rr_n    = grant_id;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      burst_cnt    <= '0;
      tx_data      <= '0;
      last_q       <= 1'b0;
    end else begin
      state        <= state_n;
      grant_id     <= gid_n;
      grant_active <= act_n;
      rr_ptr       <= rr_n;
      burst_cnt    <= burst_n;
      tx_data      <= data_n;
      last_q       <= last_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model.
// Table vectors cover arbitration; hand sequences cover bursts and reset.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        grant_active;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .MAX_BURST(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .grant_active(grant_active)
  );

  always #5 clock = ~clock;

  // uart_tx stand-in: busy two cycles after tx_start, for 20 cycles
  logic st_d1 = 1'b0;
  int   bcnt = 0;
  always @(posedge clock) begin
    st_d1 <= tx_start;
    if (st_d1) bcnt <= 20;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt > 0);

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       l;
    int         sess;
  } acc_t;

  acc_t accq[$];
  int   sess = 0;
  int   n_start = 0;
  int   n_ready = 0;
  logic ga_q = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      if (grant_active && !ga_q) sess++;
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i])
          accq.push_back('{i, req_data[i*8 +: 8], req_last[i], sess});
      if (tx_start) n_start++;
      if (req_ready != 4'b0) n_ready++;
    end
    ga_q = grant_active;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int lane, input int bound, input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!req_ready[lane] && t < bound);
    chk({nm, " ready seen"}, 32'(req_ready[lane]), 1);
  endtask

  task automatic wait_rel(input int bound, input string nm);
    int t;
    t = 0;
    while (grant_active && t < bound) begin
      @(negedge clock);
      t++;
    end
    chk({nm, " released"}, 32'(grant_active), 0);
  endtask

  task automatic send_one(input int lane);
    req_last = 4'hF;
    req_valid = 4'(1 << lane);
    wait_ready(lane, 20, "pre");
    @(negedge clock);
    req_valid = '0;
    wait_rel(100, "pre");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " ready"}, 32'(req_ready), 0);
    chk({nm, " start"}, 32'(tx_start), 0);
    chk({nm, " data"}, 32'(tx_data), 0);
    chk({nm, " gid"}, 32'(grant_id), 0);
    chk({nm, " active"}, 32'(grant_active), 0);
  endtask

  typedef struct {
    logic [3:0] valid;
    int         win;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] t3b[3];
  acc_t       a0[$];

  initial begin
    int t;
    t3b = '{8'h3C, 8'h55, 8'hAA};
    tbl[0]  = '{4'b1111, 1};
    tbl[1]  = '{4'b1111, 2};
    tbl[2]  = '{4'b1111, 3};
    tbl[3]  = '{4'b1111, 0};
    tbl[4]  = '{4'b1010, 1};
    tbl[5]  = '{4'b1010, 3};
    tbl[6]  = '{4'b0100, 2};
    tbl[7]  = '{4'b0011, 0};
    tbl[8]  = '{4'b1001, 3};
    tbl[9]  = '{4'b1000, 3};
    tbl[10] = '{4'b0110, 1};
    tbl[11] = '{4'b0110, 2};

    // single byte, latency and reset values
    do_reset();
    chk_reset_vals("rst");
    n_start = 0;
    n_ready = 0;
    accq.delete();
    req_data[7:0] = 8'hA5;
    req_last = 4'hF;
    req_valid = 4'b0001;
    @(negedge clock);
    chk("t1 ready lat", 32'(req_ready), 32'h1);
    chk("t1 active", 32'(grant_active), 1);
    @(negedge clock);
    chk("t1 start", 32'(tx_start), 1);
    chk("t1 data", 32'(tx_data), 32'hA5);
    req_valid = '0;
    wait_rel(100, "t1");
    chk("t1 starts", n_start, 1);
    chk("t1 readys", n_ready, 1);
    chk("t1 gid", 32'(grant_id), 0);

    // arbitration table, rr_ptr carries over from each previous winner
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 16 + k);
      req_last = 4'hF;
      req_valid = tbl[k].valid;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (req_ready == 4'b0 && t < 20);
      chk($sformatf("v%0d ready", k), 32'(req_ready), 32'(1 << tbl[k].win));
      chk($sformatf("v%0d gid", k), 32'(grant_id), tbl[k].win);
      @(negedge clock);
      req_valid = '0;
      chk($sformatf("v%0d start", k), 32'(tx_start), 1);
      chk($sformatf("v%0d data", k), 32'(tx_data), tbl[k].win * 16 + k);
      wait_rel(100, $sformatf("v%0d", k));
      chk($sformatf("v%0d gid hold", k), 32'(grant_id), tbl[k].win);
    end

    // all valid held, single-byte packets
    do_reset();
    accq.delete();
    req_last = 4'hF;
    req_valid = 4'hF;
    t = 0;
    while (accq.size() < 5 && t < 400) begin
      @(negedge clock);
      t++;
    end
    req_valid = '0;
    wait_rel(100, "t2");
    chk("t2 count", 32'(accq.size() >= 5), 1);
    if (accq.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("t2 id%0d", i), accq[i].id, i % 4);
      for (int i = 1; i < 5; i++)
        chk($sformatf("t2 sess%0d", i), 32'(accq[i].sess != accq[i-1].sess), 1);
    end

    // packet lock: req 2 sends 3 bytes while req 1 waits
    do_reset();
    send_one(1);
    accq.delete();
    req_data[15:8] = 8'h11;
    req_valid = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      req_data[23:16] = t3b[b];
      req_last = {1'b0, (b == 2), 1'b1, 1'b0};
      wait_ready(2, 100, $sformatf("t3 b%0d", b));
      @(negedge clock);
    end
    req_valid[2] = 1'b0;
    wait_ready(1, 100, "t3 r1");
    @(negedge clock);
    req_valid = '0;
    wait_rel(100, "t3");
    chk("t3 count", accq.size(), 4);
    if (accq.size() == 4) begin
      for (int b = 0; b < 3; b++) begin
        chk($sformatf("t3 id%0d", b), accq[b].id, 2);
        chk($sformatf("t3 d%0d", b), 32'(accq[b].d), 32'(t3b[b]));
        chk($sformatf("t3 sess%0d", b), accq[b].sess, accq[0].sess);
      end
      chk("t3 last", 32'(accq[2].l), 1);
      chk("t3 id3", accq[3].id, 1);
    end

    // burst limit, alone and with a competing requester
    for (int other = 0; other < 2; other++) begin
      do_reset();
      accq.delete();
      a0.delete();
      req_valid = (other == 1) ? 4'b0011 : 4'b0001;
      req_last = (other == 1) ? 4'b0010 : 4'b0000;
      req_data[15:8] = 8'hEE;
      for (int k = 0; k < 20; k++) begin
        req_data[7:0] = 8'(k);
        wait_ready(0, 200, $sformatf("t4.%0d b%0d", other, k));
        @(negedge clock);
      end
      req_valid = '0;
      wait_rel(200, "t4");
      foreach (accq[i]) if (accq[i].id == 0) a0.push_back(accq[i]);
      chk($sformatf("t4.%0d count", other), a0.size(), 20);
      if (a0.size() == 20 && accq.size() >= 17) begin
        for (int k = 0; k < 20; k++)
          chk($sformatf("t4.%0d d%0d", other, k), 32'(a0[k].d), k);
        chk($sformatf("t4.%0d held16", other), a0[15].sess, a0[0].sess);
        chk($sformatf("t4.%0d forced", other),
            32'(a0[16].sess != a0[15].sess), 1);
        chk($sformatf("t4.%0d next id", other), accq[16].id, other);
      end
    end

    // req 3 drops valid mid-burst
    do_reset();
    send_one(1);
    accq.delete();
    n_start = 0;
    n_ready = 0;
    req_data[31:24] = 8'h77;
    req_last = '0;
    req_valid = 4'b1000;
    wait_ready(3, 20, "t5");
    @(negedge clock);
    req_valid = '0;
    wait_rel(100, "t5");
    chk("t5 starts", n_start, 1);
    chk("t5 readys", n_ready, 1);
    chk("t5 bytes", accq.size(), 1);
    chk("t5 gid", 32'(grant_id), 3);
    req_last = 4'hF;
    req_valid = 4'b0110;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (req_ready == 4'b0 && t < 20);
    chk("t5 rr", 32'(req_ready), 32'h2);
    @(negedge clock);
    req_valid = '0;
    wait_rel(100, "t5b");

    // reset during WAIT_DONE
    do_reset();
    req_last = '0;
    req_valid = 4'b0100;
    wait_ready(2, 20, "t6");
    t = 0;
    while (!tx_busy && t < 20) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    chk("t6 busy", 32'(tx_busy), 1);
    chk("t6 active", 32'(grant_active), 1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_vals("t6");
    reset = 1'b0;
    req_last = 4'hF;
    req_valid = 4'hF;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (req_ready == 4'b0 && t < 20);
    chk("t6 first", 32'(req_ready), 32'h1);
    chk("t6 gid", 32'(grant_id), 0);
    @(negedge clock);
    req_valid = '0;
    wait_rel(100, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
